// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
package muldiv_ctrl_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSVD  = 3'd7
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   localparam int DEF_MUL_CYCLES = 5;
   localparam int DEF_DIV_CYCLES = 10;

   // True for the multi-cycle ops that occupy the unit.
   function automatic logic is_long_op(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_ctrl_arith.sv
// Combinational multiply/divide datapath working on latched operands.
// Divide-by-zero passes the current HI/LO through unchanged.
module md_arith
   import muldiv_ctrl_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] hi_in,
   input  logic [31:0] lo_in,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic [31:0]        b_div;
   logic               a_neg, b_neg;
   logic [31:0]        a_mag, b_mag;
   logic [31:0]        uq, ur, sq, sr;

   // Signed division goes through magnitudes so 0x80000000 / -1 wraps to
   // 0x80000000 with remainder 0 without relying on signed-overflow behaviour.
   always_comb begin
      prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      prod_u = {32'd0, a} * {32'd0, b};
      b_div  = (b == 32'd0) ? 32'd1 : b;
      a_neg  = a[31];
      b_neg  = b[31];
      a_mag  = a_neg ? (32'd0 - a) : a;
      b_mag  = b_neg ? (32'd0 - b_div) : b_div;
      sq     = a_mag / b_mag;
      sr     = a_mag % b_mag;
      if (a_neg ^ b_neg) sq = 32'd0 - sq;
      if (a_neg)         sr = 32'd0 - sr;
      uq     = a / b_div;
      ur     = a % b_div;

      hi_out = hi_in;
      lo_out = lo_in;
      case (op)
         MD_MULT:  begin hi_out = prod_s[63:32]; lo_out = prod_s[31:0]; end
         MD_MULTU: begin hi_out = prod_u[63:32]; lo_out = prod_u[31:0]; end
         MD_DIV:   if (b != 32'd0) begin hi_out = sr; lo_out = sq; end
         MD_DIVU:  if (b != 32'd0) begin hi_out = ur; lo_out = uq; end
         default:  ;
      endcase
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencing controller with HI/LO registers and D-stage
// stall request. Long ops hold busy for a fixed latency, then commit.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = DEF_MUL_CYCLES,
   parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        md_use_D,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        md_stall
);

   localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   md_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic [31:0]        a_q, a_d, b_q, b_d;
   logic [31:0]        hi_q, hi_d, lo_q, lo_d;
   logic [31:0]        res_hi, res_lo;

   md_arith u_arith (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .hi_in  (hi_q),
      .lo_in  (lo_q),
      .hi_out (res_hi),
      .lo_out (res_lo)
   );

   // Next-state: accept ops only in IDLE; in RUN count down and commit on 1->0.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (is_long_op(op)) begin
                  op_d    = op;
                  a_d     = a;
                  b_d     = b;
                  cnt_d   = ((op == MD_MULT) || (op == MD_MULTU)) ? CNT_W'(MUL_CYCLES)
                                                                  : CNT_W'(DIV_CYCLES);
                  state_d = ST_RUN;
               end else if (op == MD_MTHI) begin
                  hi_d = a;
               end else if (op == MD_MTLO) begin
                  lo_d = a;
               end
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               hi_d    = res_hi;
               lo_d    = res_lo;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and HI/LO registers; reset discards any in-flight result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= MD_NONE;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Stall covers the cycle a long op sits in E as well as the busy window.
   always_comb begin
      busy     = (state_q == ST_RUN);
      hi       = hi_q;
      lo       = lo_q;
      md_stall = md_use_D & (busy | (start & is_long_op(op)));
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected HI/LO pushed at issue,
// popped and compared when busy falls.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        reset, start, md_use_D;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy, md_stall;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;
   logic [63:0] sb[$];
   logic [31:0] exp_hi = 32'd0, exp_lo = 32'd0;
   bit allow_overlap = 1'b0;

   muldiv_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .md_use_D(md_use_D), .busy(busy), .hi(hi), .lo(lo), .md_stall(md_stall)
   );

   always #5 clk = ~clk;

   // Hazard logic should never issue a long op into a busy unit.
   always @(posedge clk) begin
      if (!allow_overlap && !reset && busy === 1'b1 && start === 1'b1 && op >= 3'd1 && op <= 3'd4) begin
         errors++;
         $display("FAIL overlap_assert: start op=%0d while busy", op);
      end
   end

   // Reference model: updates the shadow HI/LO.
   task automatic md_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      longint p;
      logic [63:0] pu;
      int sx, sy;
      sx = x; sy = y;
      case (o)
         3'd1: begin p = longint'(sx) * longint'(sy); exp_hi = p[63:32]; exp_lo = p[31:0]; end
         3'd2: begin pu = {32'd0, x} * {32'd0, y}; exp_hi = pu[63:32]; exp_lo = pu[31:0]; end
         3'd3: if (y != 0) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
               exp_lo = 32'h8000_0000; exp_hi = 32'd0;
            end else begin
               exp_lo = sx / sy; exp_hi = sx % sy;
            end
         end
         3'd4: if (y != 0) begin exp_lo = x / y; exp_hi = x % y; end
         default: ;
      endcase
   endtask

   // Issue one long op, measure busy length, compare committed HI/LO.
   task automatic run_long(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      int n, cyc;
      logic [63:0] e;
      n = (o <= 3'd2) ? 5 : 10;
      md_model(o, x, y);
      sb.push_back({exp_hi, exp_lo});
      @(negedge clk); start = 1'b1; op = o; a = x; b = y;
      @(negedge clk); start = 1'b0; op = 3'd0;
      cyc = 0;
      while (busy === 1'b1 && cyc < 40) begin cyc++; @(negedge clk); end
      checks++;
      if (cyc != n) begin errors++; $display("FAIL %s_busy_len: got %0d want %0d", name, cyc, n); end
      e = sb.pop_front();
      checks++;
      if ({hi, lo} !== e)
         begin errors++; $display("FAIL %s_result: got %h_%h want %h_%h", name, hi, lo, e[63:32], e[31:0]); end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; md_use_D = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_hi = 0; exp_lo = 0;
      checks++;
      if ({busy, md_stall, hi, lo} !== 66'd0)
         begin errors++; $display("FAIL reset_state: busy=%b stall=%b hi=%h lo=%h want all 0", busy, md_stall, hi, lo); end
   endtask

   task automatic test_mult;
      run_long("mult", 3'd1, 32'hFFFF_FFFE, 32'd3);
      checks++;
      if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA)
         begin errors++; $display("FAIL mult_const: got %h_%h want ffffffff_fffffffa", hi, lo); end
      run_long("multu", 3'd2, 32'hFFFF_FFFF, 32'd2);
      checks++;
      if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE)
         begin errors++; $display("FAIL multu_const: got %h_%h want 00000001_fffffffe", hi, lo); end
   endtask

   task automatic test_div;
      run_long("div", 3'd3, 32'hFFFF_FFF9, 32'd2);
      checks++;
      if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD)
         begin errors++; $display("FAIL div_const: got %h_%h want ffffffff_fffffffd", hi, lo); end
      run_long("div_zero", 3'd3, 32'd1234, 32'd0);
      run_long("divu_zero", 3'd4, 32'd99, 32'd0);
      run_long("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      checks++;
      if ({hi, lo} !== 64'h0000_0000_8000_0000)
         begin errors++; $display("FAIL div_ovf_const: got %h_%h want 00000000_80000000", hi, lo); end
      run_long("div_negdiv", 3'd3, 32'd7, 32'hFFFF_FFFE);
      run_long("divu", 3'd4, 32'hFFFF_FFF9, 32'd16);
   endtask

   task automatic test_random;
      for (int i = 0; i < 6; i++) begin
         logic [2:0] o;
         o = 3'($urandom_range(1, 4));
         run_long("rand", o, $urandom, (i == 5) ? 32'd3 : $urandom);
      end
   endtask

   task automatic test_stall;
      int cyc, bad;
      // md_use_D high: stall from the start cycle through the last busy cycle.
      md_model(3'd3, 32'd100, 32'd9);
      @(negedge clk); md_use_D = 1'b1; start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd9;
      #1;
      checks++;
      if (md_stall !== 1'b1) begin errors++; $display("FAIL stall_entry: got %b want 1", md_stall); end
      @(negedge clk); start = 1'b0; op = 3'd0;
      cyc = 0; bad = 0;
      while (busy === 1'b1 && cyc < 40) begin
         if (md_stall !== 1'b1) bad++;
         cyc++; @(negedge clk);
      end
      checks++;
      if (bad != 0 || cyc != 10) begin errors++; $display("FAIL stall_busy: low %0d cycles, busy %0d want 0/10", bad, cyc); end
      checks++;
      if (md_stall !== 1'b0) begin errors++; $display("FAIL stall_after: got %b want 0", md_stall); end
      // md_use_D low: never stall.
      md_model(3'd1, 32'd6, 32'd7);
      md_use_D = 1'b0; start = 1'b1; op = 3'd1; a = 32'd6; b = 32'd7;
      #1; bad = (md_stall !== 1'b0);
      @(negedge clk); start = 1'b0; op = 3'd0;
      cyc = 0;
      while (busy === 1'b1 && cyc < 40) begin
         if (md_stall !== 1'b0) bad++;
         cyc++; @(negedge clk);
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL stall_no_use: high %0d cycles want 0", bad); end
      checks++;
      if ({hi, lo} !== {exp_hi, exp_lo}) begin errors++; $display("FAIL stall_result: got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end
   endtask

   task automatic test_mthi_mtlo;
      logic [31:0] lo_before;
      lo_before = lo;
      @(negedge clk); start = 1'b1; op = 3'd5; a = 32'h1234_5678;
      @(negedge clk); exp_hi = 32'h1234_5678;
      checks++;
      if (hi !== exp_hi || lo !== lo_before || busy !== 1'b0)
         begin errors++; $display("FAIL mthi: hi=%h lo=%h busy=%b want %h %h 0", hi, lo, busy, exp_hi, lo_before); end
      op = 3'd6; a = 32'h9ABC_DEF0;
      @(negedge clk); start = 1'b0; op = 3'd0; exp_lo = 32'h9ABC_DEF0;
      checks++;
      if (hi !== exp_hi || lo !== exp_lo || busy !== 1'b0)
         begin errors++; $display("FAIL mtlo: hi=%h lo=%h busy=%b want %h %h 0", hi, lo, busy, exp_hi, exp_lo); end
      // op 7 and start=0 leave state alone
      start = 1'b1; op = 3'd7; a = 32'hDEAD_BEEF;
      @(negedge clk); start = 1'b0; op = 3'd5;
      @(negedge clk); op = 3'd0;
      checks++;
      if (hi !== exp_hi || lo !== exp_lo || busy !== 1'b0)
         begin errors++; $display("FAIL noop: hi=%h lo=%h busy=%b want %h %h 0", hi, lo, busy, exp_hi, exp_lo); end
   endtask

   task automatic test_ignore_start;
      int cyc;
      logic [63:0] e;
      md_model(3'd1, 32'hFFFF_FFFE, 32'd3);
      sb.push_back({exp_hi, exp_lo});
      @(negedge clk); start = 1'b1; op = 3'd1; a = 32'hFFFF_FFFE; b = 32'd3;
      @(negedge clk); start = 1'b0; op = 3'd0;
      @(negedge clk);
      allow_overlap = 1'b1;
      start = 1'b1; op = 3'd1; a = 32'd7; b = 32'd7;
      @(negedge clk); op = 3'd5; a = 32'hDEAD_0000;
      @(negedge clk); start = 1'b0; op = 3'd0; allow_overlap = 1'b0;
      cyc = 3;
      while (busy === 1'b1 && cyc < 40) begin cyc++; @(negedge clk); end
      checks++;
      if (cyc != 5) begin errors++; $display("FAIL ignore_busy_len: got %0d want 5", cyc); end
      e = sb.pop_front();
      checks++;
      if ({hi, lo} !== e) begin errors++; $display("FAIL ignore_result: got %h_%h want %h_%h", hi, lo, e[63:32], e[31:0]); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart: busy=%b want 0", busy); end
   endtask

   task automatic test_reset_mid;
      int bad;
      @(negedge clk); start = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7;
      @(negedge clk); start = 1'b0; op = 3'd0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || {hi, lo} === 64'd0) begin errors++; $display("FAIL rstmid_pre: busy=%b hi=%h lo=%h want busy 1, nonzero", busy, hi, lo); end
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      exp_hi = 0; exp_lo = 0;
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
         begin errors++; $display("FAIL rstmid: busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo); end
      bad = 0;
      repeat (12) begin
         @(negedge clk);
         if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rstmid_late_write: %0d bad cycles want 0", bad); end
   endtask

   initial begin
      test_reset;
      test_mult;
      test_div;
      test_stall;
      test_mthi_mtlo;
      test_ignore_start;
      test_random;
      test_reset_mid;
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
